// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared funct3 codes, FSM state type and byte-enable constants
//               for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } lsu_state_t;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_ALL  = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module      : lsu_align
// Description : Combinational legality/alignment check, store lane placement
//               and load lane extraction with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic        i_we,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic        o_illegal,
  output logic        o_misaligned,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_illegal = 1'b0;
    case (i_funct3)
      F3_B, F3_H, F3_W: o_illegal = 1'b0;
      F3_BU, F3_HU:     o_illegal = i_we;
      default:          o_illegal = 1'b1;
    endcase
  end

  // Unsigned variants share size bits [1:0] with their signed forms.
  always_comb begin
    o_misaligned = 1'b0;
    if (!o_illegal) begin
      if (i_funct3[1:0] == 2'b01)
        o_misaligned = i_addr_lo[0];
      else if (i_funct3[1:0] == 2'b10)
        o_misaligned = (i_addr_lo != 2'b00);
    end
  end

  always_comb begin
    o_be    = BE_ALL;
    o_wdata = 32'h0;
    if (i_we) begin
      case (i_funct3)
        F3_B: begin
          o_be    = BE_B0 << i_addr_lo;
          o_wdata = {4{i_wdata[7:0]}};
        end
        F3_H: begin
          o_be    = i_addr_lo[1] ? BE_HI : BE_LO;
          o_wdata = {2{i_wdata[15:0]}};
        end
        default: begin
          o_be    = BE_ALL;
          o_wdata = i_wdata;
        end
      endcase
    end
  end

  always_comb begin
    w_byte = 8'h0;
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_ldata = i_rdata;
    case (i_funct3)
      F3_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ldata = {24'h0, w_byte};
      F3_H:    o_ldata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ldata = {16'h0, w_half};
      default: o_ldata = i_rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : Multi-cycle RV32I load/store unit with req/ack memory port.
//               Optional WAIT timeout enabled by defining LSU_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        illegal,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  r_state;
  lsu_state_t  w_next;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_mem_req;
  logic        r_misaligned;
  logic        r_illegal;
  logic        r_bus_err;

  logic        w_idle;
  logic        w_expire;
  logic        w_illegal;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;

  assign w_idle = (r_state == S_IDLE);

  // Live inputs are checked at accept; captured fields drive the bus afterwards.
  lsu_align u_align (
    .i_funct3     (w_idle ? funct3 : r_f3),
    .i_we         (w_idle ? req_we : r_we),
    .i_addr_lo    (w_idle ? addr[1:0] : r_addr[1:0]),
    .i_wdata      (w_idle ? wdata : r_wdata),
    .i_rdata      (mem_rdata),
    .o_illegal    (w_illegal),
    .o_misaligned (w_misaligned),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_ldata      (w_ldata)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || r_state != S_WAIT)
      r_tmo_cnt <= '0;
    else
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  assign w_expire = (r_state == S_WAIT) && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_err  = r_bus_err;
`else
  assign w_expire = 1'b0;
  assign bus_err  = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid)
          w_next = (w_illegal || w_misaligned) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack || w_expire)
          w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_f3         <= 3'b000;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_rdata      <= 32'h0;
      r_mem_req    <= 1'b0;
      r_misaligned <= 1'b0;
      r_illegal    <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we         <= req_we;
            r_f3         <= funct3;
            r_addr       <= addr;
            r_wdata      <= wdata;
            r_illegal    <= w_illegal;
            r_misaligned <= w_misaligned;
            r_mem_req    <= !(w_illegal || w_misaligned);
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            if (!r_we)
              r_rdata <= w_ldata;
          end else if (w_expire) begin
            r_mem_req <= 1'b0;
            r_bus_err <= 1'b1;
          end
        end
        default: begin
          r_misaligned <= 1'b0;
          r_illegal    <= 1'b0;
          r_bus_err    <= 1'b0;
        end
      endcase
    end
  end

  assign stall      = (w_idle && req_valid) || (r_state == S_WAIT);
  assign done       = (r_state == S_RESP);
  assign rdata      = r_rdata;
  assign misaligned = r_misaligned;
  assign illegal    = r_illegal;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_req & r_we;
  assign mem_addr   = r_mem_req ? {r_addr[31:2], 2'b00} : 32'h0;
  assign mem_be     = r_mem_req ? w_be : BE_NONE;
  assign mem_wdata  = r_mem_req ? w_wdata : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall, done, misaligned, illegal, bus_err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int n_checks = 0;
  int n_pass   = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .done       (done),
    .rdata      (rdata),
    .misaligned (misaligned),
    .illegal    (illegal),
    .bus_err    (bus_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
  endtask

  // Legal access with ack in the first WAIT cycle.
  task automatic xfer(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                      input logic [3:0] exp_be, input logic [31:0] exp_wd,
                      input logic [31:0] exp_rd);
    nxt(); drive(we, f3, a, wd); mem_rdata = rd; mem_ack = 1'b0;
    smp(); check({tag, " c0 stall"}, 32'(stall), 32'd1);
           check({tag, " c0 mem_req"}, 32'(mem_req), 32'd0);
    nxt(); mem_ack = 1'b1;
    smp(); check({tag, " c1 stall"}, 32'(stall), 32'd1);
           check({tag, " c1 mem_req"}, 32'(mem_req), 32'd1);
           check({tag, " mem_addr"}, mem_addr, {a[31:2], 2'b00});
           check({tag, " mem_be"}, 32'(mem_be), 32'(exp_be));
           check({tag, " mem_we"}, 32'(mem_we), 32'(we));
           if (we) check({tag, " mem_wdata"}, mem_wdata, exp_wd);
    nxt(); mem_ack = 1'b0; req_valid = 1'b0;
    smp(); check({tag, " c2 done"}, 32'(done), 32'd1);
           check({tag, " c2 stall"}, 32'(stall), 32'd0);
           check({tag, " c2 mem_req"}, 32'(mem_req), 32'd0);
           check({tag, " flags"}, {29'h0, misaligned, illegal, bus_err}, 32'h0);
           check({tag, " rdata"}, rdata, exp_rd);
    nxt();
    smp(); check({tag, " c3 done"}, 32'(done), 32'd0);
  endtask

  task automatic fault(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic exp_mis, input logic exp_ill,
                       input logic [31:0] exp_rd);
    nxt(); drive(we, f3, a, 32'h5555_AAAA); mem_ack = 1'b0;
    smp(); check({tag, " c0 stall"}, 32'(stall), 32'd1);
           check({tag, " c0 mem_req"}, 32'(mem_req), 32'd0);
    nxt(); req_valid = 1'b0;
    smp(); check({tag, " c1 done"}, 32'(done), 32'd1);
           check({tag, " c1 mem_req"}, 32'(mem_req), 32'd0);
           check({tag, " misaligned"}, 32'(misaligned), 32'(exp_mis));
           check({tag, " illegal"}, 32'(illegal), 32'(exp_ill));
           check({tag, " rdata"}, rdata, exp_rd);
    nxt();
    smp(); check({tag, " c2 done"}, 32'(done), 32'd0);
           check({tag, " c2 flags"}, {30'h0, misaligned, illegal}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    nxt(); nxt();
    smp();
    check("reset stall", 32'(stall), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset rdata", rdata, 32'h0);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset mem_be", 32'(mem_be), 32'd0);
    nxt(); rst = 1'b0;

    xfer("SW",  1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    xfer("SB",  1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    xfer("SH",  1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h0, 4'b1100, 32'hABCD_ABCD, 32'h0);
    xfer("LB",  1'b0, 3'b000, 32'h0000_0202, 32'h0, 32'h12F3_4567, 4'b1111, 32'h0, 32'hFFFF_FFF3);
    xfer("LBU", 1'b0, 3'b100, 32'h0000_0202, 32'h0, 32'h12F3_4567, 4'b1111, 32'h0, 32'h0000_00F3);
    xfer("LH",  1'b0, 3'b001, 32'h0000_0200, 32'h0, 32'h7FFF_8001, 4'b1111, 32'h0, 32'hFFFF_8001);
    xfer("LHU", 1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'h8001_1234, 4'b1111, 32'h0, 32'h0000_8001);
    xfer("LW",  1'b0, 3'b010, 32'h0000_0204, 32'h0, 32'hCAFE_F00D, 4'b1111, 32'h0, 32'hCAFE_F00D);

    fault("LW mis",   1'b0, 3'b010, 32'h0000_0206, 1'b1, 1'b0, 32'hCAFE_F00D);
    fault("LH mis",   1'b0, 3'b001, 32'h0000_0201, 1'b1, 1'b0, 32'hCAFE_F00D);
    fault("L011 ill", 1'b0, 3'b011, 32'h0000_0201, 1'b0, 1'b1, 32'hCAFE_F00D);
    fault("S100 ill", 1'b1, 3'b100, 32'h0000_0200, 1'b0, 1'b1, 32'hCAFE_F00D);

    nxt(); req_valid = 1'b0; mem_ack = 1'b1;
    smp(); check("idle ack done", 32'(done), 32'd0);
    nxt(); mem_ack = 1'b0;
    smp(); check("idle ack done2", 32'(done), 32'd0);

`ifdef LSU_TIMEOUT_EN
    nxt(); drive(1'b0, 3'b010, 32'h0000_0400, 32'h0);
    smp(); check("tmo c0 stall", 32'(stall), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      nxt();
      smp(); check($sformatf("tmo wait%0d mem_req", i), 32'(mem_req), 32'd1);
             check($sformatf("tmo wait%0d done", i), 32'(done), 32'd0);
    end
    nxt(); req_valid = 1'b0;
    smp(); check("tmo done", 32'(done), 32'd1);
           check("tmo bus_err", 32'(bus_err), 32'd1);
           check("tmo mem_req", 32'(mem_req), 32'd0);
           check("tmo rdata", rdata, 32'hCAFE_F00D);
    nxt();
    smp(); check("tmo bus_err clr", 32'(bus_err), 32'd0);
`endif

    nxt(); drive(1'b0, 3'b001, 32'h0000_0300, 32'h0); mem_ack = 1'b0;
    smp(); check("rst c0 stall", 32'(stall), 32'd1);
    nxt();
    smp(); check("rst wait1 mem_req", 32'(mem_req), 32'd1);
    nxt();
    nxt(); rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    smp(); check("rst wait3 mem_req", 32'(mem_req), 32'd1);
           check("rst wait3 mem_addr", mem_addr, 32'h0000_0300);
    nxt(); rst = 1'b0; req_valid = 1'b0; mem_ack = 1'b0;
    smp(); check("post rst mem_req", 32'(mem_req), 32'd0);
           check("post rst stall", 32'(stall), 32'd0);
           check("post rst done", 32'(done), 32'd0);
           check("post rst rdata", rdata, 32'h0);
           check("post rst mem_addr", mem_addr, 32'h0);
           check("post rst mem_be", 32'(mem_be), 32'd0);
    nxt();
    smp(); check("post rst no done", 32'(done), 32'd0);

    xfer("LW rec", 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h1122_3344, 4'b1111, 32'h0, 32'h1122_3344);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
